bus_modport_bridge: RTL and testbench

- Two-entry elastic forwarding stage between a bus follower port (upstream, valid/ready) and a bus master port (downstream, valid/ready).
- Carries address, data and write-enable transactions in order, with no loss and no duplication.
- Also provides a transfer counter, the occupancy state, and the low byte of the last forwarded write.
- Sits between a bus producer and a bus consumer to break timing and absorb backpressure.

---
 rtl/bus_bridge_pkg.sv | 11 +
 rtl/bridge_skid_fifo.sv | 48 ++++
 rtl/bus_modport_bridge.sv | 56 +++++
 tb/tb_bus_modport_bridge.sv | 129 ++++++++++++
 4 files changed

// File: rtl/bus_bridge_pkg.sv
// bus_bridge_pkg: shared occupancy states and default widths for the bus bridge
package bus_bridge_pkg;
  typedef enum logic [1:0] {
    STATE_A = 2'd0,
    STATE_B = 2'd1,
    STATE_C = 2'd2
  } state_t;
  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int CNT_WIDTH_DEF  = 32;
endpackage

// File: rtl/bridge_skid_fifo.sv
// bridge_skid_fifo: two-entry in-order buffer with occupancy FSM; head drives the output
module bridge_skid_fifo
  import bus_bridge_pkg::*;
#(
  parameter int W = 49
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output state_t       state
);
  logic [W-1:0] head, tail;
  logic push, pop;
  assign in_ready  = !rst && (state != STATE_C);
  assign out_valid = (state != STATE_A);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = head;
  // head keeps its last value when empty so outputs stay driven
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= STATE_A;
      head  <= '0;
      tail  <= '0;
    end else begin
      case (state)
        STATE_A: if (push) begin
          head  <= in_data;
          state <= STATE_B;
        end
        STATE_B: if (push && pop) head <= in_data;
          else if (push) begin
            tail  <= in_data;
            state <= STATE_C;
          end else if (pop) state <= STATE_A;
        STATE_C: if (pop) begin
          head  <= tail;
          state <= STATE_B;
        end
        default: state <= STATE_A;
      endcase
    end
endmodule

// File: rtl/bus_modport_bridge.sv
// bus_modport_bridge: elastic two-entry forwarding stage with transfer counter and last-write byte
module bus_modport_bridge
  import bus_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [ADDR_WIDTH-1:0] s_addr,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_we,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_we,
  output logic [1:0]            state,
  output logic [CNT_WIDTH-1:0]  xfer_count,
  output logic [7:0]            data_out
);
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  we;
  } entry_t;
  entry_t in_e, out_e;
  state_t fsm_state;
  assign in_e   = '{addr: s_addr, data: s_data, we: s_we};
  assign m_addr = out_e.addr;
  assign m_data = out_e.data;
  assign m_we   = out_e.we;
  assign state  = fsm_state;
  bridge_skid_fifo #(.W($bits(entry_t))) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .in_valid (s_valid),
    .in_ready (s_ready),
    .in_data  (in_e),
    .out_valid(m_valid),
    .out_ready(m_ready),
    .out_data (out_e),
    .state    (fsm_state)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      xfer_count <= '0;
      data_out   <= '0;
    end else if (m_valid && m_ready) begin
      xfer_count <= xfer_count + 1'b1;
      if (out_e.we) data_out <= out_e.data[7:0];
    end
endmodule

// File: tb/tb_bus_modport_bridge.sv
// tb_bus_modport_bridge: directed vector table plus hand sequences for reset, streaming and wrap
module tb_bus_modport_bridge;
  logic        clk = 0, rst = 1;
  logic        s_valid = 0, s_ready, s_we = 0, m_valid, m_ready = 0, m_we;
  logic [31:0] s_addr = 0, m_addr;
  logic [15:0] s_data = 0, m_data;
  logic [1:0]  state;
  logic [3:0]  xfer_count;
  logic [7:0]  data_out;
  int errors = 0, checks = 0;

  bus_modport_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(16), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
    .s_data(s_data), .s_we(s_we), .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr),
    .m_data(m_data), .m_we(m_we), .state(state), .xfer_count(xfer_count), .data_out(data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sv;
    logic [31:0] addr;
    logic [15:0] data;
    logic        we;
    logic        mr;
    logic [1:0]  e_state;
    logic        e_sr;
    logic [31:0] e_addr;
    logic [15:0] e_data;
    logic        e_we;
    logic [3:0]  e_cnt;
    logic [7:0]  e_dout;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic stream(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_valid = 1; s_addr = 32'h100 + i; s_data = base + 16'(i); s_we = 1; m_ready = 1;
      @(posedge clk); #1;
      chk("stream_state", state, 2'd1);
      chk("stream_data", m_data, base + 16'(i));
    end
    @(negedge clk);
    s_valid = 0;
    @(posedge clk); #1;
    chk("drain_state", state, 2'd0);
  endtask

  initial begin
    //        sv  addr    data      we  mr  state sr  m_addr  m_data    we  cnt dout
    vecs[0] = '{1, 32'h10, 16'h1234, 1, 1, 2'd1, 1, 32'h10, 16'h1234, 1, 1, 8'h00};
    vecs[0].e_cnt = 0;
    vecs[1] = '{0, 32'h0,  16'h0,    0, 1, 2'd0, 1, 32'h10, 16'h1234, 1, 1, 8'h34};
    vecs[2] = '{1, 32'h20, 16'hAAAA, 1, 0, 2'd1, 1, 32'h20, 16'hAAAA, 1, 1, 8'h34};
    vecs[3] = '{1, 32'h24, 16'hBBBB, 1, 0, 2'd2, 0, 32'h20, 16'hAAAA, 1, 1, 8'h34};
    vecs[4] = '{0, 32'h0,  16'h0,    0, 0, 2'd2, 0, 32'h20, 16'hAAAA, 1, 1, 8'h34};
    vecs[5] = '{0, 32'h0,  16'h0,    0, 1, 2'd1, 1, 32'h24, 16'hBBBB, 1, 2, 8'hAA};
    vecs[6] = '{0, 32'h0,  16'h0,    0, 1, 2'd0, 1, 32'h24, 16'hBBBB, 1, 3, 8'hBB};
    vecs[7] = '{1, 32'h30, 16'h00EE, 1, 1, 2'd1, 1, 32'h30, 16'h00EE, 1, 3, 8'hBB};
    vecs[8] = '{1, 32'h34, 16'h5678, 0, 1, 2'd1, 1, 32'h34, 16'h5678, 0, 4, 8'hEE};
    vecs[9] = '{0, 32'h0,  16'h0,    0, 1, 2'd0, 1, 32'h34, 16'h5678, 0, 5, 8'hEE};

    #12;
    chk("rst_state", state, 2'd0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_m_data", m_data, 16'h0);
    chk("rst_cnt", xfer_count, 4'd0);
    @(negedge clk);
    rst = 0;
    #1 chk("release_s_ready", s_ready, 1'b1);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      s_valid = vecs[i].sv; s_addr = vecs[i].addr; s_data = vecs[i].data;
      s_we = vecs[i].we; m_ready = vecs[i].mr;
      @(posedge clk); #1;
      chk($sformatf("v%0d_state", i), state, vecs[i].e_state);
      chk($sformatf("v%0d_m_valid", i), m_valid, vecs[i].e_state != 2'd0);
      chk($sformatf("v%0d_s_ready", i), s_ready, vecs[i].e_sr);
      chk($sformatf("v%0d_m_addr", i), m_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_m_data", i), m_data, vecs[i].e_data);
      chk($sformatf("v%0d_m_we", i), m_we, vecs[i].e_we);
      chk($sformatf("v%0d_cnt", i), xfer_count, vecs[i].e_cnt);
      chk($sformatf("v%0d_dout", i), data_out, vecs[i].e_dout);
    end

    stream(8, 16'h1100);
    chk("stream8_cnt", xfer_count, 4'd13);
    chk("stream8_dout", data_out, 8'h07);

    @(negedge clk);
    s_valid = 1; s_addr = 32'h40; s_data = 16'hAAAA; s_we = 1; m_ready = 0;
    @(negedge clk);
    s_addr = 32'h44; s_data = 16'hBBBB;
    @(negedge clk);
    s_valid = 0;
    chk("fill_state", state, 2'd2);
    chk("fill_head", m_data, 16'hAAAA);
    #2 rst = 1;
    #1;
    chk("mid_rst_state", state, 2'd0);
    chk("mid_rst_m_valid", m_valid, 1'b0);
    chk("mid_rst_s_ready", s_ready, 1'b0);
    chk("mid_rst_cnt", xfer_count, 4'd0);
    chk("mid_rst_dout", data_out, 8'h00);
    chk("mid_rst_m_data", m_data, 16'h0);
    @(negedge clk);
    rst = 0;
    #1 chk("mid_release_s_ready", s_ready, 1'b1);
    chk("mid_release_state", state, 2'd0);

    stream(17, 16'h2200);
    chk("wrap_cnt", xfer_count, 4'd1);
    chk("wrap_dout", data_out, 8'h10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
